hazard_fwd_unit: RTL and testbench

Parametrised successor to the two-stage forwarding unit for the RISC-V core. It selects and muxes operand data for `NUM_SRC` execute-stage sources from `NUM_STAGES` downstream pipeline stages. It detects load-use hazards and tracks in-flight long-latency writes (divider, vector ops) in a per-register scoreboard. The result is a single EX-stage `stall` plus forwarded operand values. It sits between decode/EX operand read and the ALU input muxes.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_fwd_unit_if.sv | 50 +++++
 rtl/hazard_fwd_unit_ll_scoreboard.sv | 50 +++++
 rtl/hazard_fwd_unit.sv | 98 +++++++++
 tb/tb_hazard_fwd_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding unit: register addressing and
// the operand-select encoding used on fwd_sel.
package hazard_pkg;

  localparam int REG_AW        = 5;
  localparam int NUM_ARCH_REGS = 32;

  // fwd_sel encoding: FWD_RF selects the register file, FWD_STAGE_BASE+k stage k
  localparam int FWD_RF         = 0;
  localparam int FWD_STAGE_BASE = 1;

  function automatic int fwd_code(input int stage);
    return stage + FWD_STAGE_BASE;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Bundle of EX-stage operand, pipeline-stage and long-latency completion
// signals; master drives the pipeline side, slave is the hazard unit.
interface hazard_fwd_unit_if
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
);

  logic                                   flush;
  logic                                   ex_valid;
  logic [NUM_SRC-1:0][REG_AW-1:0]         ex_src_addr;
  logic [NUM_SRC-1:0]                     ex_src_used;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     ex_src_rf_data;
  logic [REG_AW-1:0]                      ex_rd_addr;
  logic                                   ex_rd_write;
  logic                                   ll_issue;
  logic [NUM_STAGES-1:0]                  stg_reg_write;
  logic [NUM_STAGES-1:0][REG_AW-1:0]      stg_rd_addr;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0]  stg_rd_data;
  logic [NUM_STAGES-1:0]                  stg_is_load;
  logic                                   ll_done;
  logic [REG_AW-1:0]                      ll_done_rd;

  logic [NUM_SRC-1:0][SELW-1:0]           fwd_sel;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     src_data;
  logic                                   stall;
  logic                                   ll_full;
  logic [NUM_ARCH_REGS-1:0]               busy_vec;
  logic [31:0]                            stall_cycles;

  // Plain level signals, no valid/ready handshake: stall is the only
  // back-pressure and the pipeline holds IF/ID/EX while it is high.
  modport master (
    output flush, ex_valid, ex_src_addr, ex_src_used, ex_src_rf_data,
           ex_rd_addr, ex_rd_write, ll_issue, stg_reg_write, stg_rd_addr,
           stg_rd_data, stg_is_load, ll_done, ll_done_rd,
    input  fwd_sel, src_data, stall, ll_full, busy_vec, stall_cycles
  );

  modport slave (
    input  flush, ex_valid, ex_src_addr, ex_src_used, ex_src_rf_data,
           ex_rd_addr, ex_rd_write, ll_issue, stg_reg_write, stg_rd_addr,
           stg_rd_data, stg_is_load, ll_done, ll_done_rd,
    output fwd_sel, src_data, stall, ll_full, busy_vec, stall_cycles
  );

endinterface

// File: rtl/hazard_fwd_unit_ll_scoreboard.sv
// Per-register busy bits for in-flight long-latency writes plus the
// outstanding-operation count that gates further issues.
module ll_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_LL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_acc,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic                     done,
  input  logic [REG_AW-1:0]        done_rd,
  output logic [NUM_ARCH_REGS-1:0] busy_vec,
  output logic                     ll_full
);

  localparam int CW = $clog2(MAX_LL + 1);

  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     clr;

  always_comb begin
    // Completions for registers we never marked busy are stray and ignored
    clr    = done && (done_rd != '0) && busy_q[done_rd];
    busy_d = busy_q;
    if (clr)       busy_d[done_rd]  = 1'b0;
    if (issue_acc) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    count_d = count_q;
    if (issue_acc && !clr)      count_d = count_q + CW'(1);
    else if (!issue_acc && clr) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_vec = busy_q;
  assign ll_full  = (count_q == CW'(MAX_LL));

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding, load-use / long-latency hazard detection and
// stall accounting for the RISC-V pipeline.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int MAX_LL     = 4,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input logic              clk,
  input logic              rst_n,
  hazard_fwd_unit_if.slave bus
);

  logic [NUM_SRC-1:0][SELW-1:0]       fwd_sel;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
  logic                               hazard;
  logic                               stall;
  logic                               issue_acc;
  logic                               ll_full;
  logic [NUM_ARCH_REGS-1:0]           busy_vec;
  logic [31:0]                        stall_cycles_q, stall_cycles_d;
  logic                               unused_ok;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i]  = SELW'(FWD_RF);
      src_data[i] = bus.ex_src_rf_data[i];
      if (bus.ex_src_addr[i] == '0) begin
        src_data[i] = '0;
      end else begin
        // Walk oldest to youngest so the youngest matching stage wins
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
          if (bus.stg_reg_write[k] && (bus.stg_rd_addr[k] == bus.ex_src_addr[i])) begin
            fwd_sel[i]  = SELW'(fwd_code(k));
            src_data[i] = bus.stg_rd_data[k];
          end
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.ex_valid && bus.ex_src_used[i] && (bus.ex_src_addr[i] != '0)) begin
        if (bus.stg_reg_write[0] && bus.stg_is_load[0] &&
            (bus.stg_rd_addr[0] == bus.ex_src_addr[i]))
          hazard = 1'b1;
        if (busy_vec[bus.ex_src_addr[i]])
          hazard = 1'b1;
      end
    end
    if (bus.ex_valid && bus.ex_rd_write && (bus.ex_rd_addr != '0) && busy_vec[bus.ex_rd_addr])
      hazard = 1'b1;
    if (bus.ex_valid && bus.ll_issue && ll_full)
      hazard = 1'b1;
  end

  assign stall     = hazard && !bus.flush;
  assign issue_acc = bus.ex_valid && bus.ll_issue && bus.ex_rd_write &&
                     (bus.ex_rd_addr != '0) && !stall && !bus.flush;

  ll_scoreboard #(.MAX_LL(MAX_LL)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_acc (issue_acc),
    .issue_rd  (bus.ex_rd_addr),
    .done      (bus.ll_done),
    .done_rd   (bus.ll_done_rd),
    .busy_vec  (busy_vec),
    .ll_full   (ll_full)
  );

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  // Only stage 0 can hold a not-yet-available load
  assign unused_ok = ^bus.stg_is_load;

  assign bus.fwd_sel      = fwd_sel;
  assign bus.src_data     = src_data;
  assign bus.stall        = stall;
  assign bus.ll_full      = ll_full;
  assign bus.busy_vec     = busy_vec;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a register-level model checked every
// cycle plus literal expectations taken from hand-worked scenarios.
module tb_hazard_fwd_unit;

  localparam int DW = 32;
  localparam int NS = 3;
  localparam int NG = 2;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n;

  hazard_fwd_unit_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_STAGES(NG)) bus ();

  hazard_fwd_unit #(.DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_STAGES(NG), .MAX_LL(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: which registers have a long-latency write in flight, and stalls seen
  logic [31:0]      busy_m, nxt_busy;
  longint unsigned  stall_m, nxt_stall;
  logic [NS-1:0][1:0]  e_sel;
  logic [NS-1:0][31:0] e_dat;
  logic e_stall, e_full, haz;

  initial begin
    nxt_busy  = '0;
    nxt_stall = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m  <= '0;
      stall_m <= 0;
    end else begin
      busy_m  <= nxt_busy;
      stall_m <= nxt_stall;
    end
  end

  always @(negedge clk) begin
    haz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      e_sel[i] = 2'd0;
      e_dat[i] = bus.ex_src_rf_data[i];
      if (bus.ex_src_addr[i] == 5'd0) begin
        e_dat[i] = '0;
      end else begin
        for (int k = 0; k < NG; k++) begin
          if (bus.stg_reg_write[k] && bus.stg_rd_addr[k] == bus.ex_src_addr[i]) begin
            e_sel[i] = 2'(k + 1);
            e_dat[i] = bus.stg_rd_data[k];
            break;
          end
        end
        if (bus.ex_valid && bus.ex_src_used[i]) begin
          if (bus.stg_reg_write[0] && bus.stg_is_load[0] && bus.stg_rd_addr[0] == bus.ex_src_addr[i])
            haz = 1'b1;
          if (busy_m[bus.ex_src_addr[i]]) haz = 1'b1;
        end
      end
    end
    e_full = ($countones(busy_m) == ML);
    if (bus.ex_valid && bus.ex_rd_write && bus.ex_rd_addr != 0 && busy_m[bus.ex_rd_addr]) haz = 1'b1;
    if (bus.ex_valid && bus.ll_issue && e_full) haz = 1'b1;
    e_stall = haz && !bus.flush;

    for (int i = 0; i < NS; i++) begin
      check($sformatf("fwd_sel%0d", i), 64'(bus.fwd_sel[i]), 64'(e_sel[i]));
      check($sformatf("src_data%0d", i), 64'(bus.src_data[i]), 64'(e_dat[i]));
    end
    check("stall", 64'(bus.stall), 64'(e_stall));
    check("ll_full", 64'(bus.ll_full), 64'(e_full));
    check("busy_vec", 64'(bus.busy_vec), 64'(busy_m));
    check("stall_cycles", 64'(bus.stall_cycles), 64'(stall_m));

    if (!rst_n) begin
      nxt_busy  = '0;
      nxt_stall = 0;
    end else begin
      nxt_busy = busy_m;
      if (bus.ll_done && bus.ll_done_rd != 0) nxt_busy[bus.ll_done_rd] = 1'b0;
      if (bus.ex_valid && bus.ll_issue && bus.ex_rd_write && bus.ex_rd_addr != 0 && !e_stall && !bus.flush)
        nxt_busy[bus.ex_rd_addr] = 1'b1;
      nxt_stall = stall_m;
      if (e_stall && stall_m < 64'hFFFF_FFFF) nxt_stall = stall_m + 1;
    end
  end

  task automatic idle();
    bus.flush = 0; bus.ex_valid = 0; bus.ex_src_addr = '0; bus.ex_src_used = '0;
    bus.ex_src_rf_data = '0; bus.ex_rd_addr = '0; bus.ex_rd_write = 0; bus.ll_issue = 0;
    bus.stg_reg_write = '0; bus.stg_rd_addr = '0; bus.stg_rd_data = '0;
    bus.stg_is_load = '0; bus.ll_done = 0; bus.ll_done_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ll(input logic [4:0] rd);
    idle();
    bus.ex_valid = 1; bus.ll_issue = 1; bus.ex_rd_write = 1; bus.ex_rd_addr = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step(); step();
    #1;
    check("reset_busy", 64'(bus.busy_vec), 64'h0);
    check("reset_full", 64'(bus.ll_full), 64'h0);
    check("reset_stall_cycles", 64'(bus.stall_cycles), 64'h0);
    rst_n = 1'b1;
    step();

    // Both stages write x5: youngest wins
    idle();
    bus.stg_reg_write = 2'b11; bus.stg_rd_addr[0] = 5; bus.stg_rd_addr[1] = 5;
    bus.stg_rd_data[0] = 32'hAAAA; bus.stg_rd_data[1] = 32'hBBBB;
    bus.ex_valid = 1; bus.ex_src_addr[0] = 5; bus.ex_src_used[0] = 1; bus.ex_src_rf_data[0] = 32'h5555;
    #1;
    check("fwd_both_sel", 64'(bus.fwd_sel[0]), 64'd1);
    check("fwd_both_data", 64'(bus.src_data[0]), 64'hAAAA);
    check("fwd_both_stall", 64'(bus.stall), 64'd0);
    step();

    // Stage 1 only matches; unmatched source takes RF data
    bus.stg_rd_addr[0] = 9;
    bus.ex_src_addr[1] = 8; bus.ex_src_used[1] = 1; bus.ex_src_rf_data[1] = 32'h8888;
    #1;
    check("fwd_stg1_sel", 64'(bus.fwd_sel[0]), 64'd2);
    check("fwd_stg1_data", 64'(bus.src_data[0]), 64'hBBBB);
    check("fwd_rf_sel", 64'(bus.fwd_sel[1]), 64'd0);
    check("fwd_rf_data", 64'(bus.src_data[1]), 64'h8888);
    step();

    // x0 never forwards
    idle();
    bus.stg_reg_write = 2'b01; bus.stg_rd_addr[0] = 0; bus.stg_rd_data[0] = 32'h1234;
    bus.ex_valid = 1; bus.ex_src_addr[0] = 0; bus.ex_src_used[0] = 1; bus.ex_src_rf_data[0] = 32'hDEAD;
    #1;
    check("x0_sel", 64'(bus.fwd_sel[0]), 64'd0);
    check("x0_data", 64'(bus.src_data[0]), 64'd0);
    step();

    // Load-use on x7 via rs2
    idle();
    bus.stg_reg_write = 2'b01; bus.stg_rd_addr[0] = 7; bus.stg_is_load = 2'b01;
    bus.ex_valid = 1; bus.ex_src_addr[1] = 7; bus.ex_src_used[1] = 1; bus.ex_src_rf_data[1] = 32'h1111;
    #1;
    check("loaduse_stall", 64'(bus.stall), 64'd1);
    step();
    bus.stg_reg_write = 2'b10; bus.stg_rd_addr[0] = 0; bus.stg_rd_addr[1] = 7;
    bus.stg_rd_data[1] = 32'h77; bus.stg_is_load = 2'b00;
    #1;
    check("loaduse_sel", 64'(bus.fwd_sel[1]), 64'd2);
    check("loaduse_data", 64'(bus.src_data[1]), 64'h77);
    check("loaduse_released", 64'(bus.stall), 64'd0);
    check("loaduse_count", 64'(bus.stall_cycles), 64'd1);
    step();

    // Long-latency write to x3, then a reader of x3
    issue_ll(5'd3);
    step();
    idle();
    bus.ex_valid = 1; bus.ex_src_addr[0] = 3; bus.ex_src_used[0] = 1;
    #1;
    check("raw_stall", 64'(bus.stall), 64'd1);
    check("raw_busy", 64'(bus.busy_vec), 64'h8);
    step(); step();
    bus.ll_done = 1; bus.ll_done_rd = 3;
    #1;
    check("raw_stall_at_done", 64'(bus.stall), 64'd1);
    step();
    bus.ll_done = 0;
    #1;
    check("raw_released", 64'(bus.stall), 64'd0);
    check("raw_busy_clear", 64'(bus.busy_vec), 64'h0);
    step();

    // Stray completions: non-busy register and x0
    idle(); bus.ll_done = 1; bus.ll_done_rd = 10;
    step();
    bus.ll_done_rd = 0;
    step();
    idle();
    #1;
    check("stray_busy", 64'(bus.busy_vec), 64'h0);
    check("stray_full", 64'(bus.ll_full), 64'h0);

    // Fill to capacity, then a fifth issue waits for one completion
    for (int r = 1; r <= 4; r++) begin
      issue_ll(5'(r));
      step();
    end
    issue_ll(5'd5);
    #1;
    check("cap_busy", 64'(bus.busy_vec), 64'h1E);
    check("cap_full", 64'(bus.ll_full), 64'd1);
    check("cap_stall", 64'(bus.stall), 64'd1);
    bus.ll_done = 1; bus.ll_done_rd = 1;
    step();
    bus.ll_done = 0;
    #1;
    check("cap_free_full", 64'(bus.ll_full), 64'd0);
    check("cap_free_stall", 64'(bus.stall), 64'd0);
    step();
    idle();
    #1;
    check("cap_accepted", 64'(bus.busy_vec), 64'h3C);
    check("cap_full_again", 64'(bus.ll_full), 64'd1);

    // WAW against in-flight x2
    bus.ex_valid = 1; bus.ex_rd_write = 1; bus.ex_rd_addr = 2;
    #1;
    check("waw_stall", 64'(bus.stall), 64'd1);
    step();

    // Asynchronous reset in mid-cycle with ops outstanding
    idle();
    rst_n = 1'b0;
    #1;
    check("areset_busy", 64'(bus.busy_vec), 64'h0);
    check("areset_full", 64'(bus.ll_full), 64'h0);
    check("areset_stall_cycles", 64'(bus.stall_cycles), 64'h0);
    step();
    rst_n = 1'b1;
    step();

    issue_ll(5'd1); step();
    issue_ll(5'd2); step();
    idle();
    #1;
    check("x1x2_busy", 64'(bus.busy_vec), 64'h6);

    // Flush masks a RAW hazard and blocks the ll issue it carries
    bus.ex_valid = 1; bus.ex_src_addr[0] = 1; bus.ex_src_used[0] = 1;
    bus.ll_issue = 1; bus.ex_rd_write = 1; bus.ex_rd_addr = 9; bus.flush = 1;
    #1;
    check("flush_stall", 64'(bus.stall), 64'd0);
    step();
    idle();
    #1;
    check("flush_no_set", 64'(bus.busy_vec), 64'h6);

    rst_n = 1'b0;
    #1;
    check("areset2_busy", 64'(bus.busy_vec), 64'h0);
    check("areset2_full", 64'(bus.ll_full), 64'h0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
